// File: rtl/repeat_sub_divider_pkg.sv
// Shared types and constants for the repeated-subtraction divider.
// Optional abort support elsewhere in the slice is selected by the RSD_ABORT_EN macro.
package rsd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } rsd_state_e;

    localparam int RSD_WIDTH_DEFAULT = 4;

    // Wide all-ones pattern; callers truncate it to their own WIDTH.
    localparam logic [31:0] RSD_DBZ_QUOTIENT = '1;

endpackage

// File: rtl/repeat_sub_divider_if.sv
// Start/done handshake and operand/result bus of the repeated-subtraction divider.
// Macro RSD_ABORT_EN adds the abort request line.
interface repeat_sub_divider_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
`ifdef RSD_ABORT_EN
    logic             abort;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

`ifdef RSD_ABORT_EN
    modport master (
        output start, dividend, divisor, abort,
        input  busy, done, quotient, remainder, div_by_zero
    );
    modport slave (
        input  start, dividend, divisor, abort,
        output busy, done, quotient, remainder, div_by_zero
    );
`else
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );
    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
`endif

endinterface

// File: rtl/repeat_sub_divider_sub_stage.sv
// Combinational compare-and-subtract step used once per clock by the divider.
module sub_stage #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             ge
);

    assign diff = a - b;
    assign ge   = (a >= b);

endmodule

// File: rtl/repeat_sub_divider.sv
// Unsigned divider: removes the divisor once per clock until remainder < divisor.
// Macro RSD_ABORT_EN enables the abort input (RUN -> IDLE, results cleared).
module repeat_sub_divider
    import rsd_pkg::*;
#(
    parameter int WIDTH = RSD_WIDTH_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    repeat_sub_divider_if.slave bus
);

    rsd_state_e       state_reg, state_next;
    logic [WIDTH-1:0] quotient_reg, quotient_next;
    logic [WIDTH-1:0] remainder_reg, remainder_next;
    logic [WIDTH-1:0] div_reg, div_next;
    logic             dbz_reg, dbz_next;

    logic [WIDTH-1:0] step_diff;
    logic             step_ge;

    sub_stage #(.WIDTH(WIDTH)) u_sub_stage (
        .a    (remainder_reg),
        .b    (div_reg),
        .diff (step_diff),
        .ge   (step_ge)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            div_reg       <= '0;
            dbz_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            quotient_reg  <= quotient_next;
            remainder_reg <= remainder_next;
            div_reg       <= div_next;
            dbz_reg       <= dbz_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        quotient_next  = quotient_reg;
        remainder_next = remainder_reg;
        div_next       = div_reg;
        dbz_next       = dbz_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    remainder_next = bus.dividend;
                    div_next       = bus.divisor;
                    dbz_next       = (bus.divisor == '0);
                    // A zero divisor skips RUN and reports the all-ones quotient.
                    if (bus.divisor == '0) begin
                        quotient_next = WIDTH'(RSD_DBZ_QUOTIENT);
                        state_next    = FIN;
                    end else begin
                        quotient_next = '0;
                        state_next    = RUN;
                    end
                end
            end
            RUN: begin
`ifdef RSD_ABORT_EN
                if (bus.abort) begin
                    quotient_next  = '0;
                    remainder_next = '0;
                    state_next     = IDLE;
                end else
`endif
                if (step_ge) begin
                    remainder_next = step_diff;
                    quotient_next  = quotient_reg + WIDTH'(1);
                end else begin
                    state_next = FIN;
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign bus.busy        = (state_reg != IDLE);
    assign bus.done        = (state_reg == FIN);
    assign bus.quotient    = quotient_reg;
    assign bus.remainder   = remainder_reg;
    assign bus.div_by_zero = dbz_reg;

endmodule
